// File: rtl/des_expansion_pkg.sv
// DES expansion types, E-table and reference expansion function (package des_pkg).
package des_pkg;

    localparam int unsigned HALF_W = 32;
    localparam int unsigned EXP_W  = 48;

    typedef logic [HALF_W-1:0] half_block_t;
    typedef logic [EXP_W-1:0]  exp_block_t;
    typedef logic [EXP_W-1:0]  subkey_t;

    // Source bit (1-based, MSB-first) for each output bit 1..48
    localparam logic [5:0] E_TABLE [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    // DES bit n (1-based MSB-first) lives at vector index 32-n
    function automatic exp_block_t des_expand(input half_block_t r);
        exp_block_t e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[6'(47 - i)] = r[5'(32 - int'(E_TABLE[6'(i)]))];
        end
        return e;
    endfunction

endpackage

// File: rtl/des_expansion_map.sv
// Purely combinational DES E mapping: 32-bit half-block in, 48-bit expanded block out.
module des_expansion_map
    import des_pkg::*;
(
    input  logic [31:0] i_data,
    output logic [47:0] o_data
);

    // Fixed bit permutation, no arithmetic
    assign o_data = des_expand(i_data);

endmodule

// File: rtl/des_expansion.sv
// Registered DES expansion permutation with valid/ready handshake.
// LATENCY (1 or 2) sets the number of register stages; the pipeline moves as one unit.
// Optional macro DES_EXPANSION_KEY_XOR_EN adds key_in, XORed into the expanded block.
module des_expansion
    import des_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] data_out
`ifdef DES_EXPANSION_KEY_XOR_EN
    ,
    input  logic [47:0] key_in
`endif
);

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("des_expansion: LATENCY must be 1 or 2");
    end

    logic       w_advance;
    exp_block_t w_map;
    exp_block_t w_cap;
    logic       w_out_valid;
    exp_block_t w_out_data;
    logic       r_v1;
    exp_block_t r_d1;

    des_expansion_map u_map (
        .i_data (data_in),
        .o_data (w_map)
    );

    // Key is folded in at capture so it travels with its half-block
`ifdef DES_EXPANSION_KEY_XOR_EN
    assign w_cap = w_map ^ key_in;
`else
    assign w_cap = w_map;
`endif

    // Whole pipeline advances unless the output is held by backpressure
    assign w_advance = !w_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Stage 1: capture stage; data loads only for a valid incoming beat
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else if (w_advance) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_d1 <= w_cap;
            end
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic       r_v2;
        exp_block_t r_d2;

        // Stage 2: follows stage 1 in lockstep; bubbles are not squeezed out
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else if (w_advance) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= r_d1;
                end
            end
        end

        assign w_out_valid = r_v2;
        assign w_out_data  = r_d2;
    end else begin : g_lat1
        assign w_out_valid = r_v1;
        assign w_out_data  = r_d1;
    end

    assign out_valid = w_out_valid;
    assign data_out  = w_out_data;

endmodule

// File: tb/tb_des_expansion.sv
// Self-checking bench for des_expansion: one LATENCY=1 and one LATENCY=2 instance,
// checked every cycle against a nibble-view model and a scoreboard queue.
module tb_des_expansion;
    import des_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        iv   [2];
    logic        ir   [2];
    half_block_t di   [2];
    logic        ov   [2];
    logic        orr  [2];
    exp_block_t  dout [2];
    subkey_t     key  [2];

    int n_tests = 0;
    int n_fail  = 0;

    exp_block_t q0[$];
    exp_block_t q1[$];
    logic       prev_rst   [2];
    logic       prev_stall [2];
    exp_block_t prev_dout  [2];

    des_expansion #(.LATENCY(1)) dut0 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in(di[0]), .out_valid(ov[0]), .out_ready(orr[0]), .data_out(dout[0])
`ifdef DES_EXPANSION_KEY_XOR_EN
        , .key_in(key[0])
`endif
    );

    des_expansion #(.LATENCY(2)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in(di[1]), .out_valid(ov[1]), .out_ready(orr[1]), .data_out(dout[1])
`ifdef DES_EXPANSION_KEY_XOR_EN
        , .key_in(key[1])
`endif
    );

    // Nibble view: group k = {lsb of previous nibble, nibble k, msb of next nibble}
    function automatic exp_block_t model(input half_block_t r, input subkey_t k);
        logic [3:0] n [8];
        exp_block_t e;
        for (int j = 0; j < 8; j++) n[3'(j)] = 4'(r >> (28 - 4 * j));
        e = '0;
        for (int j = 0; j < 8; j++)
            e = {e[41:0], n[3'((j + 7) % 8)][0], n[3'(j)], n[3'((j + 1) % 8)][3]};
        return e ^ k;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_block_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int d);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction

    function automatic void qpush(input int d, input exp_block_t v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic void qclear(input int d);
        if (d == 0) q0.delete(); else q1.delete();
    endfunction

    // Compare process: mid-cycle sampling of both instances against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!n_rst) begin
                if (prev_rst[d]) begin
                    check($sformatf("rst_out_valid%0d", d), 48'(ov[d]), 48'h0);
                    check($sformatf("rst_data_out%0d", d), dout[d], 48'h0);
                    check($sformatf("rst_in_ready%0d", d), 48'(ir[d]), 48'h1);
                end
                qclear(d);
                prev_stall[d] = 1'b0;
            end else begin
                check($sformatf("in_ready%0d", d), 48'(ir[d]), 48'(!ov[d] || orr[d]));
                if (prev_stall[d]) begin
                    check($sformatf("stall_valid%0d", d), 48'(ov[d]), 48'h1);
                    check($sformatf("stall_data%0d", d), dout[d], prev_dout[d]);
                end
                if (ov[d]) begin
                    if (qsize(d) == 0) begin
                        check($sformatf("spurious_out%0d", d), dout[d], 48'hx);
                    end else begin
                        check($sformatf("data_out%0d", d), dout[d], qfront(d));
                        if (orr[d]) qpop(d);
                    end
                end
                if (iv[d] && ir[d]) qpush(d, model(di[d], key[d]));
                prev_stall[d] = ov[d] && !orr[d];
                prev_dout[d]  = dout[d];
            end
            prev_rst[d] = !n_rst;
        end
    end

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; orr[d] = 1'b1; di[d] = '0; key[d] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat with a hand-computed literal expectation at the exact latency
    task automatic single(input int d, input half_block_t x, input subkey_t k, input exp_block_t lit);
        iv[d] = 1'b1; di[d] = x; key[d] = k; orr[d] = 1'b1;
        tick();
        iv[d] = 1'b0; key[d] = '0;
        if (d == 1) begin
            check("lat2_early_valid", 48'(ov[d]), 48'h0);
            tick();
        end
        check($sformatf("lit_valid%0d_%h", d, x), 48'(ov[d]), 48'h1);
        check($sformatf("lit_data%0d_%h", d, x), dout[d], lit);
        tick();
        tick();
    endtask

    initial begin
        prev_rst[0] = 1'b0; prev_rst[1] = 1'b0;
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        prev_dout[0] = '0; prev_dout[1] = '0;
        idle_all();
        n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // Pin the model itself
        check("model_zero", model(32'h00000000, '0), 48'h000000000000);
        check("model_1234", model(32'h12341234, '0), 48'h0a41a80a41a8);
        check("model_wrap", model(32'h80000001, '0), 48'hc00000000003);

        // Directed literal beats on both latencies
        for (int d = 0; d < 2; d++) begin
            single(d, 32'h00000000, '0, 48'h000000000000);
            single(d, 32'h12341234, '0, 48'h0a41a80a41a8);
            single(d, 32'habcd1234, '0, 48'h557e5a8a41a9);
            single(d, 32'h0000aaaa, '0, 48'h000001555554);
            single(d, 32'h80000001, '0, 48'hc00000000003);
        end
`ifdef DES_EXPANSION_KEY_XOR_EN
        single(0, 32'h12341234, 48'hffffffffffff, 48'hf5be57f5be57);
        single(1, 32'h12341234, 48'hffffffffffff, 48'hf5be57f5be57);
`endif

        // Backpressure: three beats with a three-cycle stall mid-stream (LATENCY=1)
        iv[0] = 1'b1; di[0] = 32'h12341234; orr[0] = 1'b1;
        tick();
        di[0] = 32'habcd1234; orr[0] = 1'b0;
        tick();
        check("bp_in_ready", 48'(ir[0]), 48'h0);
        check("bp_hold_data", dout[0], 48'h0a41a80a41a8);
        tick();
        tick();
        check("bp_hold_data2", dout[0], 48'h0a41a80a41a8);
        orr[0] = 1'b1;
        tick();
        di[0] = 32'h0000aaaa;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();

        // LATENCY=2 back-to-back stream: first valid two edges after first capture
        iv[1] = 1'b1; orr[1] = 1'b1; di[1] = 32'h11111111;
        tick();
        check("l2_stream_early", 48'(ov[1]), 48'h0);
        di[1] = 32'h22222222;
        tick();
        check("l2_stream_first", 48'(ov[1]), 48'h1);
        check("l2_stream_data", dout[1], model(32'h11111111, '0));
        for (int i = 0; i < 3; i++) begin
            di[1] = 32'h33333333 + 32'(i);
            tick();
            check("l2_stream_rate", 48'(ov[1]), 48'h1);
        end
        iv[1] = 1'b0;
        repeat (4) tick();

        // Randomized traffic with one mid-operation reset
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]  = 1'($urandom_range(0, 1));
                orr[d] = ($urandom_range(0, 9) < 7);
                di[d]  = $urandom;
`ifdef DES_EXPANSION_KEY_XOR_EN
                key[d] = {16'($urandom), $urandom};
`endif
            end
            n_rst = (c != 300);
            tick();
        end
        n_rst = 1'b1;

        // Drain and confirm nothing was lost
        idle_all();
        repeat (5) tick();
        check("drain_q0", 48'(q0.size()), 48'h0);
        check("drain_q1", 48'(q1.size()), 48'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
